uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of entries; SHALL be a power of two, 4..256.
REQ-002 Parameter AW, default 4, pointer width; SHALL equal log2(DEPTH).
REQ-003 clock  input  1  system main clock; all state SHALL update on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 done_flag  input  1  frame-received strobe from the receiver, baud-clock domain, high for at least 3 clock periods.
REQ-006 data_in  input  8  received byte, stable while done_flag is high.
REQ-007 error_in  input  3  {stop, start, parity} error flags, stable while done_flag is high.
REQ-008 rd_en  input  1  pop request for the head entry.
REQ-009 clear_overrun  input  1  clears the overrun flag.
REQ-010 rd_data  output  8  head byte, first-word-fall-through.
REQ-011 rd_err  output  3  head entry error flags.
REQ-012 empty  output  1  FIFO holds 0 entries.
REQ-013 full  output  1  FIFO holds DEPTH entries.
REQ-014 count  output  AW+1  number of stored entries, 0..DEPTH.
REQ-015 overrun  output  1  sticky flag: a frame was lost because the FIFO was full.
REQ-016 err_drop_count  output  8  saturating count of frames filtered for errors (see Configuration).

Function
REQ-017 done_flag SHALL pass through a 2-flop synchronizer followed by a third flop; the write strobe SHALL be s2 & ~s3, so it is exactly one clock long per done_flag rise.
REQ-018 On the write strobe, {error_in, data_in} SHALL be sampled and written at wr_ptr on the same edge; empty SHALL deassert after the 3rd rising edge that samples done_flag high.
REQ-019 When the FIFO is not empty, rd_data/rd_err SHALL show the head entry combinationally from storage; when empty they SHALL be 0.
REQ-020 rd_en with empty=0 SHALL advance rd_ptr on that edge; rd_en with empty=1 SHALL be ignored with no state change.
REQ-021 Pointers SHALL be AW bits and wrap from DEPTH-1 to 0; count SHALL be a separate AW+1 register.
REQ-022 Write with full=0 and no read: count+1. Read with no write: count-1. Read and write on the same edge: both occur and count is unchanged.
REQ-023 Write strobe with full=1 and rd_en=1: the pop and the push SHALL both occur and overrun SHALL NOT set.
REQ-024 Write strobe with full=1 and rd_en=0: the frame SHALL be discarded, storage SHALL be unchanged, and overrun SHALL set.
REQ-025 clear_overrun SHALL clear overrun on the next edge; an overrun event on the same edge SHALL win, leaving the flag set.
REQ-026 empty = (count==0); full = (count==DEPTH); both SHALL be combinational from count.

Reset
REQ-027 reset_n low SHALL asynchronously set wr_ptr, rd_ptr, count, overrun and err_drop_count to 0; empty=1, full=0, rd_data=0, rd_err=0.
REQ-028 Synchronizer flops s1..s3 SHALL reset to 1, so a done_flag already high at reset release produces no write.
REQ-029 Storage array contents SHALL NOT require reset.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries and any write strobe in flight.

Configuration
REQ-031 Macro UART_RX_FIFO_ERR_FILTER_EN.
- Defined: a write strobe with error_in != 3'b000 SHALL not be stored, and err_drop_count SHALL increment, saturating at 255.
- A filtered frame SHALL NOT set overrun, even when the FIFO is full.
REQ-032 With UART_RX_FIFO_ERR_FILTER_EN undefined, all frames SHALL be stored with their error flags and err_drop_count SHALL be constant 0.

Verification
REQ-033 Reset, then one done_flag pulse with data_in=8'hA5, error_in=0 -> empty falls on the 3rd edge; rd_data=8'hA5, rd_err=0, count=1; after rd_en for 1 clock, empty=1 and rd_data=0.
REQ-034 16 frames 8'h00..8'h0F, then a 17th frame 8'hFF with rd_en=0 -> full=1, overrun=1, count=16; 16 pops return 8'h00..8'h0F in order and 8'hFF never appears.
REQ-035 FIFO full, 17th write strobe on the same edge as rd_en=1 -> overrun stays 0, count stays 16, and the last entry read is the new byte.
REQ-036 20 write/read pairs at steady state, count oscillating 0/1 -> pointers wrap past 15, and data order is preserved across the wrap.
REQ-037 With UART_RX_FIFO_ERR_FILTER_EN defined, a frame with error_in=3'b001 followed by a clean frame 8'h3C -> count=1, rd_data=8'h3C, err_drop_count=1; undefined: count=2, head rd_err=3'b001.
REQ-038 reset_n pulsed low with 5 entries stored and done_flag held high -> count=0, empty=1 immediately; no write after release until done_flag falls and rises again.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive-side FIFO for a UART. Frame-done strobes arrive from the baud-clock
//   domain. Each strobe is synchronised and edge-detected into a single-cycle
//   write. The received byte and its error flags are then pushed into a
//   first-word-fall-through store.
//
//   Optional feature, macro UART_RX_FIFO_ERR_FILTER_EN:
//     When defined, frames with any error flag set are dropped rather than
//     stored, and the drops are counted in err_drop_count (saturating at 255).
//     When undefined, every frame is stored and err_drop_count is tied to 0.
//
//   Ports
//     clock          : system clock, rising edge
//     reset_n        : asynchronous active-low reset
//     done_flag      : frame-received strobe (async, >= 3 clocks high)
//     data_in        : received byte, stable while done_flag is high
//     error_in       : {stop, start, parity} error flags
//     rd_en          : pop the head entry (ignored when empty)
//     clear_overrun  : clear the sticky overrun flag
//     rd_data/rd_err : head entry, 0 when empty
//     empty/full     : occupancy flags decoded from count
//     count          : stored entries, 0..DEPTH
//     overrun        : sticky, a frame was lost to a full FIFO
//     err_drop_count : frames filtered for errors
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          done_flag,
  input  logic [7:0]    data_in,
  input  logic [2:0]    error_in,
  input  logic          rd_en,
  input  logic          clear_overrun,
  output logic [7:0]    rd_data,
  output logic [2:0]    rd_err,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overrun,
  output logic [7:0]    err_drop_count
);

  logic            s1_q, s2_q, s3_q;
  logic [10:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic            overrun_q, overrun_d;
  logic [10:0]     head;
  logic            wr_stb, frame_bad, pop, push, ovr_evt;

  // Rising edge of the synchronised done_flag. The chain resets to 1, so a
  // strobe already high when reset releases is not treated as a new frame.
  assign wr_stb = s2_q & ~s3_q;

`ifdef UART_RX_FIFO_ERR_FILTER_EN
  logic [7:0] drop_q;
  assign frame_bad      = |error_in;
  assign err_drop_count = drop_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      drop_q <= 8'h00;
    else if (wr_stb && frame_bad && drop_q != 8'hFF)
      drop_q <= drop_q + 8'h01;
  end
`else
  assign frame_bad      = 1'b0;
  assign err_drop_count = 8'h00;
`endif

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;

  assign pop  = rd_en & ~empty;
  // A full FIFO still accepts a frame when a pop frees a slot on the same edge.
  assign push    = wr_stb & ~frame_bad & (~full | pop);
  assign ovr_evt = wr_stb & ~frame_bad & full & ~pop;

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + (AW+1)'(1);
    else if (pop && !push)
      count_d = count_q - (AW+1)'(1);
  end

  // A lost frame outranks a simultaneous clear so the loss is never hidden.
  always_comb begin
    overrun_d = overrun_q;
    if (ovr_evt)
      overrun_d = 1'b1;
    else if (clear_overrun)
      overrun_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      s3_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      s1_q      <= done_flag;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage carries no reset; occupancy is governed by count and the pointers.
  always_ff @(posedge clock) begin
    if (push)
      mem_q[wr_ptr_q] <= {error_in, data_in};
  end

  assign head    = empty ? 11'h000 : mem_q[rd_ptr_q];
  assign rd_data = head[7:0];
  assign rd_err  = head[10:8];
  assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: scenario tasks plus randomized traffic checked
// against a queue-based model of the FIFO behaviour.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef UART_RX_FIFO_ERR_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          done_flag = 1'b0;
  logic [7:0]    data_in = 8'h00;
  logic [2:0]    error_in = 3'b000;
  logic          rd_en = 1'b0;
  logic          clear_overrun = 1'b0;
  logic [7:0]    rd_data;
  logic [2:0]    rd_err;
  logic          empty, full, overrun;
  logic [AW:0]   count;
  logic [7:0]    err_drop_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [10:0] q[$];
  bit          m_ovr = 1'b0;
  int          m_drop = 0;

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock(clock), .reset_n(reset_n), .done_flag(done_flag),
    .data_in(data_in), .error_in(error_in), .rd_en(rd_en),
    .clear_overrun(clear_overrun), .rd_data(rd_data), .rd_err(rd_err),
    .empty(empty), .full(full), .count(count), .overrun(overrun),
    .err_drop_count(err_drop_count)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] head();
    return (q.size() > 0) ? q[0] : 11'h000;
  endfunction

  // Model of one received frame, with optional same-edge pop and clear.
  task automatic model_frame(input logic [7:0] d, input logic [2:0] e,
                             input bit rd, input bit clr);
    bit evt;
    evt = 1'b0;
    if (FILT && e != 3'b000) begin
      if (m_drop < 255) m_drop++;
      if (rd && q.size() > 0) void'(q.pop_front());
    end else if (rd && q.size() > 0) begin
      void'(q.pop_front());
      q.push_back({e, d});
    end else if (q.size() == DEPTH) begin
      evt = 1'b1;
      m_ovr = 1'b1;
    end else begin
      q.push_back({e, d});
    end
    if (clr && !evt) m_ovr = 1'b0;
  endtask

  // done_flag high for 3 clocks; rd_en/clear_overrun aligned with the write edge.
  task automatic frame(input logic [7:0] d, input logic [2:0] e,
                       input bit rd, input bit clr);
    @(negedge clock);
    done_flag = 1'b1; data_in = d; error_in = e;
    @(negedge clock);
    @(negedge clock);
    rd_en = rd; clear_overrun = clr;
    @(negedge clock);
    rd_en = 1'b0; clear_overrun = 1'b0; done_flag = 1'b0;
    model_frame(d, e, rd, clr);
    repeat (3) @(negedge clock);
  endtask

  task automatic pop();
    @(negedge clock);
    rd_en = 1'b1;
    @(negedge clock);
    rd_en = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    q.delete(); m_ovr = 1'b0; m_drop = 0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    #1;
    total_cnt++; if (count !== 5'd0) $display("FAIL reset_count got %0d exp 0", count); else pass_cnt++;
    total_cnt++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL reset_flags got empty=%b full=%b exp 1/0", empty, full); else pass_cnt++;
    total_cnt++; if (rd_data !== 8'h00 || rd_err !== 3'b000) $display("FAIL reset_head got %h/%b exp 00/000", rd_data, rd_err); else pass_cnt++;
    total_cnt++; if (overrun !== 1'b0 || err_drop_count !== 8'h00) $display("FAIL reset_ovr_drop got %b/%0d exp 0/0", overrun, err_drop_count); else pass_cnt++;
    @(negedge clock);
    reset_n = 1'b1;
    pop();
    total_cnt++; if (count !== 5'd0 || empty !== 1'b1) $display("FAIL pop_empty got count=%0d empty=%b exp 0/1", count, empty); else pass_cnt++;
  endtask

  task automatic test_single();
    @(negedge clock);
    done_flag = 1'b1; data_in = 8'hA5; error_in = 3'b000;
    @(negedge clock);
    total_cnt++; if (empty !== 1'b1) $display("FAIL single_edge1 empty got %b exp 1", empty); else pass_cnt++;
    @(negedge clock);
    total_cnt++; if (empty !== 1'b1) $display("FAIL single_edge2 empty got %b exp 1", empty); else pass_cnt++;
    @(negedge clock);
    total_cnt++; if (empty !== 1'b0) $display("FAIL single_edge3 empty got %b exp 0", empty); else pass_cnt++;
    total_cnt++; if (rd_data !== 8'hA5 || rd_err !== 3'b000 || count !== 5'd1)
      $display("FAIL single_head got %h/%b/%0d exp a5/000/1", rd_data, rd_err, count); else pass_cnt++;
    done_flag = 1'b0;
    q.push_back(11'h0A5);
    repeat (3) @(negedge clock);
    total_cnt++; if (count !== 5'd1) $display("FAIL single_onewrite count got %0d exp 1", count); else pass_cnt++;
    pop();
    total_cnt++; if (empty !== 1'b1 || rd_data !== 8'h00) $display("FAIL single_pop got empty=%b data=%h exp 1/00", empty, rd_data); else pass_cnt++;
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 16; i++) frame(8'(i), 3'b000, 1'b0, 1'b0);
    total_cnt++; if (full !== 1'b1 || count !== 5'd16 || overrun !== 1'b0)
      $display("FAIL ovr_fill got full=%b count=%0d ovr=%b exp 1/16/0", full, count, overrun); else pass_cnt++;
    frame(8'hFF, 3'b000, 1'b0, 1'b0);
    total_cnt++; if (full !== 1'b1 || count !== 5'd16 || overrun !== 1'b1)
      $display("FAIL ovr_17th got full=%b count=%0d ovr=%b exp 1/16/1", full, count, overrun); else pass_cnt++;
    frame(8'hEE, 3'b000, 1'b0, 1'b1);
    total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_clear_loses got %b exp 1", overrun); else pass_cnt++;
    @(negedge clock); clear_overrun = 1'b1;
    @(negedge clock); clear_overrun = 1'b0; m_ovr = 1'b0;
    total_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_clear got %b exp 0", overrun); else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      total_cnt++; if (rd_data !== 8'(i)) $display("FAIL ovr_order[%0d] got %h exp %h", i, rd_data, 8'(i)); else pass_cnt++;
      pop();
    end
    total_cnt++; if (empty !== 1'b1 || rd_data !== 8'h00) $display("FAIL ovr_drain got empty=%b data=%h exp 1/00", empty, rd_data); else pass_cnt++;
  endtask

  task automatic test_full_rw();
    logic [7:0] last;
    last = 8'h00;
    for (int i = 0; i < 16; i++) frame(8'($urandom_range(0, 254)), 3'b000, 1'b0, 1'b0);
    frame(8'h5A, 3'b000, 1'b1, 1'b0);
    total_cnt++; if (overrun !== 1'b0 || count !== 5'd16) $display("FAIL fullrw got ovr=%b count=%0d exp 0/16", overrun, count); else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      total_cnt++; if (rd_data !== head()[7:0]) $display("FAIL fullrw_data[%0d] got %h exp %h", i, rd_data, head()[7:0]); else pass_cnt++;
      last = rd_data;
      pop();
    end
    total_cnt++; if (last !== 8'h5A) $display("FAIL fullrw_last got %h exp 5a", last); else pass_cnt++;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      frame(8'(8'h40 + i), 3'b000, 1'b0, 1'b0);
      total_cnt++; if (rd_data !== 8'(8'h40 + i) || count !== 5'd1)
        $display("FAIL wrap[%0d] got %h/%0d exp %h/1", i, rd_data, count, 8'(8'h40 + i)); else pass_cnt++;
      pop();
    end
    total_cnt++; if (count !== 5'd0) $display("FAIL wrap_end count got %0d exp 0", count); else pass_cnt++;
  endtask

  task automatic test_filter();
    do_reset();
    frame(8'h77, 3'b001, 1'b0, 1'b0);
    frame(8'h3C, 3'b000, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_ERR_FILTER_EN
    total_cnt++; if (count !== 5'd1 || rd_data !== 8'h3C || err_drop_count !== 8'd1)
      $display("FAIL filter got %0d/%h/%0d exp 1/3c/1", count, rd_data, err_drop_count); else pass_cnt++;
`else
    total_cnt++; if (count !== 5'd2 || rd_err !== 3'b001 || rd_data !== 8'h77 || err_drop_count !== 8'd0)
      $display("FAIL nofilter got %0d/%b/%h/%0d exp 2/001/77/0", count, rd_err, rd_data, err_drop_count); else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) frame(8'(8'h80 + i), 3'b000, 1'b0, 1'b0);
    total_cnt++; if (count !== 5'd5) $display("FAIL rstmid_pre count got %0d exp 5", count); else pass_cnt++;
    @(negedge clock);
    done_flag = 1'b1; data_in = 8'h99; error_in = 3'b000;
    @(negedge clock);
    @(negedge clock);
    #2 reset_n = 1'b0;
    q.delete(); m_ovr = 1'b0; m_drop = 0;
    #1;
    total_cnt++; if (count !== 5'd0 || empty !== 1'b1 || rd_data !== 8'h00)
      $display("FAIL rstmid_async got %0d/%b/%h exp 0/1/00", count, empty, rd_data); else pass_cnt++;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (6) @(negedge clock);
    total_cnt++; if (count !== 5'd0 || empty !== 1'b1) $display("FAIL rstmid_held got %0d/%b exp 0/1", count, empty); else pass_cnt++;
    done_flag = 1'b0;
    repeat (3) @(negedge clock);
    frame(8'h12, 3'b000, 1'b0, 1'b0);
    total_cnt++; if (count !== 5'd1 || rd_data !== 8'h12) $display("FAIL rstmid_after got %0d/%h exp 1/12", count, rd_data); else pass_cnt++;
  endtask

  task automatic test_random();
    int op;
    logic [2:0] e;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 3);
      if (op <= 1) begin
        e = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        frame(8'($urandom), e, bit'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
      end else if (op == 2) begin
        pop();
      end else begin
        @(negedge clock); clear_overrun = 1'b1;
        @(negedge clock); clear_overrun = 1'b0; m_ovr = 1'b0;
      end
      total_cnt++;
      if (count !== 5'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH) ||
          overrun !== m_ovr || {rd_err, rd_data} !== head() || err_drop_count !== 8'(m_drop))
        $display("FAIL random[%0d] got cnt=%0d ovr=%b head=%h drop=%0d exp cnt=%0d ovr=%b head=%h drop=%0d",
                 n, count, overrun, {rd_err, rd_data}, err_drop_count, q.size(), m_ovr, head(), m_drop);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overrun();
    test_full_rw();
    test_wrap();
    test_filter();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
